// File: rtl/rx_frame_engine_p.sv
// rx_frame_engine_p: XGMII-style receive framing engine.
// Delineates frames, checks length/framing, optionally strips FCS.
module rx_frame_engine_p #(
  parameter int LANES     = 8,
  parameter int MAX_LEN   = 1518,
  parameter int JUMBO_LEN = 9018,
  parameter int LEN_W     = 14,
  parameter int CNT_W     = 32
) (
  input  logic               rxclk,
  input  logic               reset_n,
  input  logic [8*LANES-1:0] rxd,
  input  logic [LANES-1:0]   rxc,
  input  logic               recv_enable,
  input  logic               inband_fcs,
  input  logic               jumbo_enable,
  input  logic               vlan_enable,
  output logic [8*LANES-1:0] rx_data,
  output logic [LANES-1:0]   rx_data_valid,
  output logic               rx_good_frame,
  output logic               rx_bad_frame,
  output logic [LEN_W-1:0]   frame_length,
  output logic [CNT_W-1:0]   good_cnt,
  output logic [CNT_W-1:0]   bad_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int PRE_BEATS = 8 / LANES;
  localparam int TW = $clog2(LANES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [7:0] C_START = 8'hFB;
  localparam logic [7:0] C_TERM  = 8'hFD;
  localparam logic [7:0] C_IDLE  = 8'h07;
  localparam logic [7:0] C_SFD   = 8'hD5;

  function automatic logic [LANES-1:0] lo_mask(input int n);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  logic [1:0]         state, state_n;
  logic               pidx, pidx_n;
  logic [LEN_W-1:0]   len, len_n;
  logic               frm_err, err_n;

  logic [8*LANES-1:0] hold_data, h_data_n;
  logic [LANES-1:0]   hold_mask, h_mask_n;
  logic               hold_last, h_last_n;
  logic               hold_bad, h_bad_n;
  logic [LEN_W-1:0]   hold_len, h_len_n;

  logic [LANES-1:0]   em_mask;
  logic               em_last, em_bad;
  logic [LEN_W-1:0]   em_len;
  logic               drop_inc, do_start;

  logic               found, term_hit, term_any, all_idle;
  logic [TW-1:0]      term_lane;
  int                 tl;
  logic               start_hit, data_err;
  logic               pre_bad, pre_last;
  int                 pre_pos;
  logic [TW:0]        add;
  logic [LEN_W:0]     sum;
  logic [LEN_W-1:0]   len_add;
  int                 limit;
  logic               tot_bad;

  // Lane scan: lowest control lane, terminator presence, all-idle beat
  always_comb begin
    found     = 1'b0;
    term_hit  = 1'b0;
    term_lane = '0;
    term_any  = 1'b0;
    all_idle  = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (rxc[i] && rxd[8*i +: 8] == C_TERM) term_any = 1'b1;
      if (!rxc[i] || rxd[8*i +: 8] != C_IDLE) all_idle = 1'b0;
      if (rxc[i] && !found) begin
        found = 1'b1;
        if (rxd[8*i +: 8] == C_TERM) begin
          term_hit  = 1'b1;
          term_lane = TW'(i);
        end
      end
    end
    tl        = int'(term_lane);
    start_hit = rxc[0] && rxd[7:0] == C_START;
    data_err  = |rxc;
  end

  // Preamble check of the current beat at its position in the 8 bytes
  always_comb begin
    pre_pos  = pidx ? LANES : 0;
    pre_bad  = 1'b0;
    pre_last = (int'(pidx) == PRE_BEATS - 1);
    for (int i = 0; i < LANES; i++) begin
      if (pre_pos + i == 0) begin
        if (!start_hit) pre_bad = 1'b1;
      end else if (rxc[i]) begin
        pre_bad = 1'b1;
      end else if (pre_pos + i == 7 && rxd[8*i +: 8] != C_SFD) begin
        pre_bad = 1'b1;
      end
    end
  end

  // Saturating length update and final length verdict
  always_comb begin
    add     = term_hit ? {1'b0, term_lane} : (TW+1)'(LANES);
    sum     = {1'b0, len} + (LEN_W+1)'(add);
    len_add = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
    if (jumbo_enable)     limit = JUMBO_LEN;
    else if (vlan_enable) limit = MAX_LEN + 4;
    else                  limit = MAX_LEN;
    tot_bad = frm_err || int'(len_add) < 64 ||
              int'(len_add) > limit || (&len_add);
  end

  // Next state, holding-register load and emission of the held beat
  always_comb begin
    state_n  = state;
    pidx_n   = pidx;
    len_n    = len;
    err_n    = frm_err;
    drop_inc = 1'b0;
    do_start = 1'b0;
    h_data_n = hold_data;
    h_mask_n = '0;
    h_last_n = 1'b0;
    h_bad_n  = 1'b0;
    h_len_n  = hold_len;
    em_mask  = hold_mask;
    em_last  = hold_last;
    em_bad   = hold_bad;
    em_len   = hold_len;
    case (state)
      S_IDLE: do_start = start_hit;
      S_PRE: begin
        if (pre_bad) begin
          state_n = S_DROP;
          pidx_n  = 1'b0;
        end else if (pre_last) begin
          state_n = S_DATA;
          pidx_n  = 1'b0;
          len_n   = '0;
          err_n   = 1'b0;
        end else begin
          pidx_n = 1'b1;
        end
      end
      S_DATA: begin
        if (start_hit) begin
          em_last  = 1'b1;
          em_bad   = 1'b1;
          em_len   = len;
          do_start = 1'b1;
        end else if (term_hit) begin
          state_n = S_IDLE;
          if (inband_fcs ? (tl == 0) : (tl <= 4)) begin
            if (!inband_fcs && tl < 4)
              em_mask = lo_mask(LANES - 4 + tl);
            em_last = 1'b1;
            em_bad  = tot_bad;
            em_len  = len_add;
          end else begin
            h_data_n = rxd;
            h_mask_n = lo_mask(inband_fcs ? tl : tl - 4);
            h_last_n = 1'b1;
            h_bad_n  = tot_bad;
            h_len_n  = len_add;
          end
        end else begin
          h_data_n = rxd;
          h_mask_n = '1;
          len_n    = len_add;
          err_n    = frm_err | data_err;
        end
      end
      S_DROP: if (term_any || all_idle) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (do_start) begin
      if (!recv_enable) begin
        drop_inc = 1'b1;
        state_n  = S_DROP;
      end else if (pre_bad) begin
        state_n = S_DROP;
      end else if (pre_last) begin
        state_n = S_DATA;
        len_n   = '0;
        err_n   = 1'b0;
      end else begin
        state_n = S_PRE;
        pidx_n  = 1'b1;
      end
    end
  end

  // Framing state, length accumulator and holding register
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pidx      <= 1'b0;
      len       <= '0;
      frm_err   <= 1'b0;
      hold_data <= '0;
      hold_mask <= '0;
      hold_last <= 1'b0;
      hold_bad  <= 1'b0;
      hold_len  <= '0;
    end else begin
      state     <= state_n;
      pidx      <= pidx_n;
      len       <= len_n;
      frm_err   <= err_n;
      hold_data <= h_data_n;
      hold_mask <= h_mask_n;
      hold_last <= h_last_n;
      hold_bad  <= h_bad_n;
      hold_len  <= h_len_n;
    end
  end

  // Client output register, frame pulses and saturating statistics
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data       <= '0;
      rx_data_valid <= '0;
      rx_good_frame <= 1'b0;
      rx_bad_frame  <= 1'b0;
      frame_length  <= '0;
      good_cnt      <= '0;
      bad_cnt       <= '0;
      drop_cnt      <= '0;
    end else begin
      rx_data       <= hold_data;
      rx_data_valid <= em_mask;
      rx_good_frame <= em_last && !em_bad;
      rx_bad_frame  <= em_last && em_bad;
      if (em_last) frame_length <= em_len;
      if (em_last && !em_bad && good_cnt != '1)
        good_cnt <= good_cnt + CNT_W'(1);
      if (em_last && em_bad && bad_cnt != '1)
        bad_cnt <= bad_cnt + CNT_W'(1);
      if (drop_inc && drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule
